// File: rtl/sc_config_pkg.sv
// Shared definitions for the scan-converter config master: bus widths,
// slave register map, FSM state encoding and byteenable helper.
package sc_config_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   // Status registers (read-only on the slave side)
   localparam logic [ADDR_W-1:0] FE_STATUS      = 4'd0;
   localparam logic [ADDR_W-1:0] FE_STATUS2     = 4'd1;
   localparam logic [ADDR_W-1:0] LT_STATUS      = 4'd2;
   // Config registers (shadowed by the master)
   localparam logic [ADDR_W-1:0] HV_IN_CONFIG   = 4'd3;
   localparam logic [ADDR_W-1:0] HV_IN_CONFIG2  = 4'd4;
   localparam logic [ADDR_W-1:0] HV_IN_CONFIG3  = 4'd5;
   localparam logic [ADDR_W-1:0] HV_OUT_CONFIG  = 4'd6;
   localparam logic [ADDR_W-1:0] HV_OUT_CONFIG2 = 4'd7;
   localparam logic [ADDR_W-1:0] HV_OUT_CONFIG3 = 4'd8;
   localparam logic [ADDR_W-1:0] XY_OUT_CONFIG  = 4'd9;
   localparam logic [ADDR_W-1:0] XY_OUT_CONFIG2 = 4'd10;
   localparam logic [ADDR_W-1:0] MISC_CONFIG    = 4'd11;
   localparam logic [ADDR_W-1:0] SL_CONFIG      = 4'd12;
   localparam logic [ADDR_W-1:0] SL_CONFIG2     = 4'd13;

   localparam logic [BE_W-1:0] BYTEEN_C     = 4'hF;
   localparam logic [BE_W-1:0] BYTEEN_OFF_C = 4'h0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WRITE   = 2'd1,
      ST_POLL_RD = 2'd2
   } sc_state_e;

   function automatic logic [BE_W-1:0] sc_byteenable(input logic active);
      return active ? BYTEEN_C : BYTEEN_OFF_C;
   endfunction

endpackage

// File: rtl/sc_config_master_if.sv
// Avalon-MM bus between the config master and the scan-converter register slave.
interface sc_config_master_if;
   import sc_config_pkg::*;

   logic [ADDR_W-1:0] avalon_m_address;
   logic [DATA_W-1:0] avalon_m_writedata;
   logic [BE_W-1:0]   avalon_m_byteenable;
   logic              avalon_m_write;
   logic              avalon_m_read;
   logic              avalon_m_chipselect;
   logic [DATA_W-1:0] avalon_m_readdata;
   logic              avalon_m_waitrequest_n;

   modport master (
      output avalon_m_address,
      output avalon_m_writedata,
      output avalon_m_byteenable,
      output avalon_m_write,
      output avalon_m_read,
      output avalon_m_chipselect,
      input  avalon_m_readdata,
      input  avalon_m_waitrequest_n
   );

   modport slave (
      input  avalon_m_address,
      input  avalon_m_writedata,
      input  avalon_m_byteenable,
      input  avalon_m_write,
      input  avalon_m_read,
      input  avalon_m_chipselect,
      output avalon_m_readdata,
      output avalon_m_waitrequest_n
   );

endinterface

// File: rtl/sc_dirty_arbiter.sv
// Lowest-set-bit priority encoder over the shadow dirty vector.
module sc_dirty_arbiter #(
   parameter int NUM_REGS = 11,
   parameter int IDX_W    = 4
) (
   input  logic [NUM_REGS-1:0] dirty,
   output logic                found,
   output logic [IDX_W-1:0]    idx
);

   logic [IDX_W-1:0] idx_s;

   // Scan from the top down so the lowest set bit is the last one to land.
   always_comb begin
      idx_s = '0;
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         idx_s = dirty[i] ? IDX_W'(i) : idx_s;
      end
   end

   assign found = |dirty;
   assign idx   = idx_s;

endmodule

// File: rtl/sc_config_master.sv
// Avalon-MM master: flushes dirty shadow config registers to the scan-converter
// slave and periodically polls status registers 0..2 as one atomic burst.
module sc_config_master
   import sc_config_pkg::*;
#(
   parameter int FIRST_CFG_ADDR = 3,
   parameter int NUM_REGS       = 11,
   parameter int POLL_DIV       = 1024
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              shadow_wr_i,
   input  logic [ADDR_W-1:0] shadow_addr_i,
   input  logic [DATA_W-1:0] shadow_data_i,
   output logic              busy_o,
   output logic [DATA_W-1:0] fe_status_o,
   output logic [DATA_W-1:0] fe_status2_o,
   output logic [DATA_W-1:0] lt_status_o,
   output logic              status_valid_o,
   sc_config_master_if.master bus
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int CNT_W = $clog2(POLL_DIV);
   localparam int AX_W  = ADDR_W + 1;

   localparam logic [CNT_W-1:0]  POLL_RELOAD_C = CNT_W'(POLL_DIV - 1);
   localparam logic [AX_W-1:0]   CFG_LO_C      = AX_W'(FIRST_CFG_ADDR);
   localparam logic [AX_W-1:0]   CFG_HI_C      = AX_W'(FIRST_CFG_ADDR + NUM_REGS);
   localparam logic [ADDR_W-1:0] CFG_BASE_C    = ADDR_W'(FIRST_CFG_ADDR);

   sc_state_e state_r, state_s;

   logic [ADDR_W-1:0]   addr_r, addr_s;
   logic [DATA_W-1:0]   wdata_r, wdata_s;
   logic                write_r, write_s;
   logic                read_r, read_s;
   logic                cs_r;
   logic [BE_W-1:0]     be_r;
   logic [IDX_W-1:0]    cur_idx_r, cur_idx_s;
   logic                wr_hit_r, wr_hit_s;

   logic [DATA_W-1:0]   shadow_r [NUM_REGS];
   logic [NUM_REGS-1:0] dirty_r, dirty_s;

   logic [CNT_W-1:0]    cnt_r;
   logic                pend_r;

   logic [DATA_W-1:0]   rd0_r, rd1_r;
   logic [DATA_W-1:0]   fe_r, fe2_r, lt_r;
   logic                valid_r;

   logic [AX_W-1:0]     addr_ext_s;
   logic                shadow_hit_s;
   logic [IDX_W-1:0]    sidx_s;
   logic                arb_found_s;
   logic [IDX_W-1:0]    arb_idx_s;
   logic                clr_dirty_s;
   logic                pend_clr_s;
   logic                cap_s;
   logic                done_s;

   assign addr_ext_s   = {1'b0, shadow_addr_i};
   assign shadow_hit_s = shadow_wr_i && (addr_ext_s >= CFG_LO_C) && (addr_ext_s < CFG_HI_C);
   assign sidx_s       = IDX_W'(addr_ext_s - CFG_LO_C);

   sc_dirty_arbiter #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_arbiter (
      .dirty (dirty_r),
      .found (arb_found_s),
      .idx   (arb_idx_s)
   );

   // Bus FSM next-state and next-output logic.
   always_comb begin
      state_s     = state_r;
      addr_s      = addr_r;
      wdata_s     = wdata_r;
      write_s     = write_r;
      read_s      = read_r;
      cur_idx_s   = cur_idx_r;
      wr_hit_s    = wr_hit_r;
      clr_dirty_s = 1'b0;
      pend_clr_s  = 1'b0;
      cap_s       = 1'b0;
      done_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (arb_found_s) begin
               state_s   = ST_WRITE;
               addr_s    = CFG_BASE_C + ADDR_W'(arb_idx_s);
               wdata_s   = shadow_r[arb_idx_s];
               write_s   = 1'b1;
               cur_idx_s = arb_idx_s;
               // A shadow write landing on the launch edge must also keep the bit set.
               wr_hit_s  = shadow_hit_s && (sidx_s == arb_idx_s);
            end else if (pend_r) begin
               state_s = ST_POLL_RD;
               addr_s  = FE_STATUS;
               read_s  = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (bus.avalon_m_waitrequest_n) begin
               state_s     = ST_IDLE;
               addr_s      = 4'd0;
               wdata_s     = 32'd0;
               write_s     = 1'b0;
               clr_dirty_s = !(wr_hit_r || (shadow_hit_s && (sidx_s == cur_idx_r)));
            end else begin
               wr_hit_s = wr_hit_r || (shadow_hit_s && (sidx_s == cur_idx_r));
            end
         end
         ST_POLL_RD: begin
            if (bus.avalon_m_waitrequest_n) begin
               cap_s = 1'b1;
               if (addr_r == LT_STATUS) begin
                  state_s    = ST_IDLE;
                  addr_s     = 4'd0;
                  read_s     = 1'b0;
                  done_s     = 1'b1;
                  pend_clr_s = 1'b1;
               end else begin
                  addr_s = addr_r + 4'd1;
               end
            end else begin
               state_s = ST_POLL_RD;
            end
         end
         default: begin
            state_s = ST_IDLE;
            addr_s  = 4'd0;
            wdata_s = 32'd0;
            write_s = 1'b0;
            read_s  = 1'b0;
         end
      endcase
   end

   // Bus FSM state and registered bus outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r   <= ST_IDLE;
         addr_r    <= 4'd0;
         wdata_r   <= 32'd0;
         write_r   <= 1'b0;
         read_r    <= 1'b0;
         cs_r      <= 1'b0;
         be_r      <= BYTEEN_OFF_C;
         cur_idx_r <= '0;
         wr_hit_r  <= 1'b0;
      end else begin
         state_r   <= state_s;
         addr_r    <= addr_s;
         wdata_r   <= wdata_s;
         write_r   <= write_s;
         read_r    <= read_s;
         cs_r      <= write_s | read_s;
         be_r      <= sc_byteenable(write_s | read_s);
         cur_idx_r <= cur_idx_s;
         wr_hit_r  <= wr_hit_s;
      end
   end

   // Dirty vector: set wins over the completion clear of the same index.
   always_comb begin
      dirty_s = dirty_r;
      if (clr_dirty_s) begin
         dirty_s[cur_idx_r] = 1'b0;
      end else begin
         dirty_s = dirty_s;
      end
      if (shadow_hit_s) begin
         dirty_s[sidx_s] = 1'b1;
      end else begin
         dirty_s = dirty_s;
      end
   end

   // Shadow register file and dirty bits.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            shadow_r[i] <= 32'd0;
         end
         dirty_r <= '0;
      end else begin
         if (shadow_hit_s) begin
            shadow_r[sidx_s] <= shadow_data_i;
         end
         dirty_r <= dirty_s;
      end
   end

   // Free-running poll timer; an expiry while a poll is pending is dropped.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_r  <= POLL_RELOAD_C;
         pend_r <= 1'b0;
      end else begin
         cnt_r <= (cnt_r == '0) ? POLL_RELOAD_C : (cnt_r - CNT_W'(1));
         if (pend_clr_s) begin
            pend_r <= 1'b0;
         end else if (cnt_r == '0) begin
            pend_r <= 1'b1;
         end
      end
   end

   // Status capture: addresses 0/1 are held until address 2 lands, then all publish together.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd0_r   <= 32'd0;
         rd1_r   <= 32'd0;
         fe_r    <= 32'd0;
         fe2_r   <= 32'd0;
         lt_r    <= 32'd0;
         valid_r <= 1'b0;
      end else begin
         if (cap_s && (addr_r == FE_STATUS)) begin
            rd0_r <= bus.avalon_m_readdata;
         end
         if (cap_s && (addr_r == FE_STATUS2)) begin
            rd1_r <= bus.avalon_m_readdata;
         end
         if (done_s) begin
            fe_r  <= rd0_r;
            fe2_r <= rd1_r;
            lt_r  <= bus.avalon_m_readdata;
         end
         valid_r <= done_s;
      end
   end

   assign bus.avalon_m_address    = addr_r;
   assign bus.avalon_m_writedata  = wdata_r;
   assign bus.avalon_m_byteenable = be_r;
   assign bus.avalon_m_write      = write_r;
   assign bus.avalon_m_read       = read_r;
   assign bus.avalon_m_chipselect = cs_r;

   assign busy_o         = (|dirty_r) || (state_r != ST_IDLE);
   assign fe_status_o    = fe_r;
   assign fe_status2_o   = fe2_r;
   assign lt_status_o    = lt_r;
   assign status_valid_o = valid_r;

endmodule
